conv1d_seq: RTL and testbench
=============================

# conv1d_seq

Hardware sequencer that drives the conv1d accelerator command port so that a whole run of output positions is computed without per-step CPU polling. It accepts a job descriptor (start ring position, output count, ring length), then for each position issues set-start-x, start, status-poll and read-result commands to conv1d. Each quantised result is streamed out on a valid/ready port. It sits between the CFU command decoder and conv1d. Buffer and parameter loading (cmds 1–5, 12–18) stay with the CPU while the sequencer is idle.

## Interface
- `DATA_W`, 32, width of conv1d `inp0`/`inp1`/`ret` and result data
- `CNT_W`, 16, width of job output count
- `POLL_LIMIT`, 4096, max poll cycles per position before timeout (only with the macro)

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `job_valid`  in  1  job descriptor valid
- `job_ready`  out  1  sequencer idle and able to take a job
- `job_start_x`  in  DATA_W  first ring position
- `job_count`  in  CNT_W  number of output positions
- `job_ring_len`  in  8  ring length in positions; 0 is treated as 1
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result consumer ready
- `res_data`  out  DATA_W  quantised result (conv1d cmd 7)
- `res_last`  out  1  marks the final result of the job
- `dp_en`  out  1  conv1d `en`
- `dp_cmd`  out  7  conv1d `cmd`
- `dp_inp0`  out  DATA_W  conv1d `inp0`; always 0
- `dp_inp1`  out  DATA_W  conv1d `inp1`
- `dp_ret`  in  DATA_W  conv1d `ret` (registered inside conv1d; reflects the command of the previous `en` cycle)
- `busy`  out  1  state != IDLE
- `err_timeout`  out  1  sticky poll-timeout flag

## Operation
- States: IDLE, SET_X, START, POLL, READ, CAPTURE, PUSH.
- `dp_*` outputs are a combinational decode of the registered state.
- IDLE:
  - `job_ready`=1, `dp_en`=0.
  - A job is accepted when `job_valid && job_ready`. On accept, latch the descriptor, clear `err_timeout` and load `cur_x`.
  - `cur_x` = `job_start_x` if `job_start_x` < ring_len, else 0.
  - `job_count`=0 is accepted and the block returns to IDLE the next cycle. No commands are issued and no result is produced.
- SET_X: `dp_en`=1, cmd 8, `dp_inp1`=`cur_x`. Next state START.
- START: `dp_en`=1, cmd 6. Next state POLL; clear the poll counter.
- POLL:
  - `dp_en`=1, cmd 9 every cycle. `en` must stay high because conv1d only advances its MAC loop when enabled.
  - The first POLL cycle is a guard cycle: `dp_ret` is ignored, since it may hold a stale finished flag.
  - From the second cycle on, `dp_ret[0]`=1 moves to READ.
- READ: `dp_en`=1, cmd 7. Next state CAPTURE.
- CAPTURE: `dp_en`=1, cmd 9. Register `dp_ret` into `res_data`. Set `res_last` = (remaining count == 1). Next state PUSH.
- PUSH:
  - `dp_en`=0; `res_valid`=1 until `res_ready`.
  - On handshake, decrement the remaining count and advance `cur_x`: `cur_x+1`, wrapping to 0 when it equals ring_len.
  - Count now 0 → IDLE; otherwise → SET_X.
- Handshake rules:
  - `res_data` and `res_last` are stable while `res_valid`=1 and `res_ready`=0.
  - `job_ready` is low in every state except IDLE.
- Reset (any time, including mid-job):
  - All state → IDLE.
  - `dp_en`=0, `dp_cmd`=0, `dp_inp1`=0.
  - `res_valid`=0, `res_last`=0, `res_data`=0.
  - `busy`=0, `err_timeout`=0, `job_ready`=1.
  - conv1d has no reset; its state is re-initialised by the next START.

## Timing
- Per position, with conv1d compute C cycles and immediate `res_ready`: SET_X 1 + START 1 + POLL (1 guard + ≥C) + READ 1 + CAPTURE 1 + PUSH 1.
- For depth D, C = 2·ceil(8D/8)+1, so `res_valid` rises 6+C cycles after SET_X.
- Job accept to first SET_X: 1 cycle.
- Last PUSH handshake to `job_ready`=1: 1 cycle.
- A new job may be presented in the same cycle `job_ready` rises.
- Back-to-back positions: the cycle after a PUSH handshake is SET_X.

## Configuration
- `CONV1D_SEQ_TIMEOUT_EN`:
  - Defined: a poll counter runs in POLL. When it reaches `POLL_LIMIT` without done, set `err_timeout`=1 (sticky until the next job accept), drop the job with no `res_valid` and no `res_last`, and go to IDLE.
  - Undefined: poll indefinitely, no counter logic, `err_timeout` tied to 0.

## Test plan
- Depth 2, start_x 0, count 3, ring_len 9 → `dp_cmd` issues 8 with `inp1` 0,1,2 in order. Three results equal the reference model; `res_last` only on the third.
- start_x 8, count 3, ring_len 9 → `cur_x` sequence 8, 0, 1 (wrap-around).
- `res_ready` held low 20 cycles in PUSH → `res_valid` and `res_data` stable. No SET_X is issued until the handshake.
- count 0 → `job_ready` drops 1 cycle, no `dp_en` pulse, no `res_valid`.
- Stale `dp_ret`=1 left from the previous job → no premature READ; guard cycle ignored.
- Macro defined, `POLL_LIMIT`=16, `dp_ret` forced 0 → `err_timeout`=1 after 16 POLL cycles, IDLE, no result. `rst_n` low mid-POLL → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/conv1d_seq_if.sv
// rtl/conv1d_seq_if.sv - job, result and conv1d command-port bundle for conv1d_seq
interface conv1d_seq_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    // Job descriptor
    logic              job_valid;
    logic              job_ready;
    logic [DATA_W-1:0] job_start_x;
    logic [CNT_W-1:0]  job_count;
    logic [7:0]        job_ring_len;

    // Result stream
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_last;

    // conv1d command port
    logic              dp_en;
    logic [6:0]        dp_cmd;
    logic [DATA_W-1:0] dp_inp0;
    logic [DATA_W-1:0] dp_inp1;
    logic [DATA_W-1:0] dp_ret;

    // Sequencer side
    modport master (
        input  job_valid, job_start_x, job_count, job_ring_len,
        output job_ready,
        output res_valid, res_data, res_last,
        input  res_ready,
        output dp_en, dp_cmd, dp_inp0, dp_inp1,
        input  dp_ret
    );

    // Environment side: job source, result sink and conv1d
    modport slave (
        output job_valid, job_start_x, job_count, job_ring_len,
        input  job_ready,
        input  res_valid, res_data, res_last,
        output res_ready,
        input  dp_en, dp_cmd, dp_inp0, dp_inp1,
        output dp_ret
    );
endinterface

// File: rtl/conv1d_seq.sv
// rtl/conv1d_seq.sv - conv1d run sequencer (optional poll timeout: CONV1D_SEQ_TIMEOUT_EN)
module conv1d_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
`ifdef CONV1D_SEQ_TIMEOUT_EN
    ,
    parameter int POLL_LIMIT = 4096
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    conv1d_seq_if.master  bus,
    output logic          busy,
    output logic          err_timeout
);

    localparam logic [6:0] CMD_START  = 7'd6;
    localparam logic [6:0] CMD_RESULT = 7'd7;
    localparam logic [6:0] CMD_SET_X  = 7'd8;
    localparam logic [6:0] CMD_STATUS = 7'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_X,
        S_START,
        S_POLL,
        S_READ,
        S_CAPTURE,
        S_PUSH
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] cur_x;
    logic [7:0]        ring_len;
    logic [CNT_W-1:0]  remaining;
    logic              poll_guard;
    logic [DATA_W-1:0] res_data_q;
    logic              res_last_q;

    logic [7:0]        job_ring_eff;
    logic [DATA_W-1:0] job_ring_ext;
    logic [DATA_W-1:0] ring_ext;
    logic [DATA_W-1:0] x_inc;

`ifdef CONV1D_SEQ_TIMEOUT_EN
    localparam int              POLL_W    = $clog2(POLL_LIMIT) + 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);

    logic [POLL_W-1:0] poll_cnt;
    logic              timeout_q;
`endif

    // Ring-length normalisation (0 means a single position) and the wrap candidate
    always_comb begin
        job_ring_eff = (bus.job_ring_len == 8'd0) ? 8'd1 : bus.job_ring_len;
        job_ring_ext = {{(DATA_W-8){1'b0}}, job_ring_eff};
        ring_ext     = {{(DATA_W-8){1'b0}}, ring_len};
        x_inc        = cur_x + DATA_W'(1);
    end

    // Sequencer FSM: one command per state, result held in PUSH until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_x      <= '0;
            ring_len   <= 8'd1;
            remaining  <= '0;
            poll_guard <= 1'b0;
            res_data_q <= '0;
            res_last_q <= 1'b0;
`ifdef CONV1D_SEQ_TIMEOUT_EN
            poll_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        ring_len  <= job_ring_eff;
                        remaining <= bus.job_count;
                        cur_x     <= (bus.job_start_x < job_ring_ext) ? bus.job_start_x : '0;
`ifdef CONV1D_SEQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        // An empty job parks in PUSH for one cycle with nothing to
                        // offer, so job_ready still drops without touching conv1d.
                        state <= (bus.job_count == '0) ? S_PUSH : S_SET_X;
                    end
                end
                S_SET_X: begin
                    state <= S_START;
                end
                S_START: begin
                    poll_guard <= 1'b1;
`ifdef CONV1D_SEQ_TIMEOUT_EN
                    poll_cnt   <= '0;
`endif
                    state <= S_POLL;
                end
                S_POLL: begin
                    // dp_ret in the first poll cycle still answers an older
                    // command and may carry a finished flag from the last run.
                    poll_guard <= 1'b0;
                    if (!poll_guard && bus.dp_ret[0]) begin
                        state <= S_READ;
                    end
`ifdef CONV1D_SEQ_TIMEOUT_EN
                    else if (poll_cnt == POLL_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                    end
`endif
                end
                S_READ: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res_data_q <= bus.dp_ret;
                    res_last_q <= (remaining == CNT_W'(1));
                    state      <= S_PUSH;
                end
                S_PUSH: begin
                    if (remaining == '0) begin
                        state <= S_IDLE;
                    end else if (bus.res_ready) begin
                        remaining  <= remaining - CNT_W'(1);
                        cur_x      <= (x_inc == ring_ext) ? '0 : x_inc;
                        res_last_q <= 1'b0;
                        state      <= (remaining == CNT_W'(1)) ? S_IDLE : S_SET_X;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // conv1d command decode from the registered state
    always_comb begin
        bus.dp_en   = 1'b0;
        bus.dp_cmd  = 7'd0;
        bus.dp_inp1 = '0;
        case (state)
            S_SET_X: begin
                bus.dp_en   = 1'b1;
                bus.dp_cmd  = CMD_SET_X;
                bus.dp_inp1 = cur_x;
            end
            S_START: begin
                bus.dp_en  = 1'b1;
                bus.dp_cmd = CMD_START;
            end
            S_POLL: begin
                bus.dp_en  = 1'b1;
                bus.dp_cmd = CMD_STATUS;
            end
            S_READ: begin
                bus.dp_en  = 1'b1;
                bus.dp_cmd = CMD_RESULT;
            end
            S_CAPTURE: begin
                bus.dp_en  = 1'b1;
                bus.dp_cmd = CMD_STATUS;
            end
            default: begin
            end
        endcase
    end

    assign bus.dp_inp0   = '0;
    assign bus.job_ready = (state == S_IDLE);
    assign bus.res_valid = (state == S_PUSH) && (remaining != '0);
    assign bus.res_data  = res_data_q;
    assign bus.res_last  = res_last_q;
    assign busy          = (state != S_IDLE);

`ifdef CONV1D_SEQ_TIMEOUT_EN
    assign err_timeout = timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_conv1d_seq.sv
// tb/tb_conv1d_seq.sv - self-checking bench for conv1d_seq with a behavioural conv1d
module tb_conv1d_seq;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv1d_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    conv1d_seq #(
        .DATA_W(DATA_W),
        .CNT_W(CNT_W)
`ifdef CONV1D_SEQ_TIMEOUT_EN
        ,
        .POLL_LIMIT(16)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_f(input logic [31:0] x);
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Behavioural conv1d: ret answers the previous enabled command, compute takes 2*depth+1 polls
    int          depth = 2;
    bit          stuck = 1'b0;
    logic [31:0] m_x = '0;
    logic [31:0] m_ret = 32'd1;
    int          m_cnt = 0;
    bit          m_done = 1'b1;

    always @(posedge clk) begin
        if (bus.dp_en) begin
            case (bus.dp_cmd)
                7'd8: m_x <= bus.dp_inp1;
                7'd6: begin
                    m_cnt  <= 2 * depth + 1;
                    m_done <= 1'b0;
                end
                7'd9: begin
                    m_ret <= {31'b0, m_done};
                    if (m_cnt > 0) begin
                        m_cnt <= m_cnt - 1;
                        if (m_cnt == 1 && !stuck) m_done <= 1'b1;
                    end
                end
                7'd7: m_ret <= ref_f(m_x);
                default: ;
            endcase
        end
    end
    assign bus.dp_ret = m_ret;

    // Result consumer: 0 always ready, 1 random, 2 held off
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.res_ready = 1'b1;
            1: bus.res_ready = ($urandom_range(0, 3) != 0);
            default: bus.res_ready = 1'b0;
        endcase
    end

    // Monitor
    logic [31:0] setx_q[$];
    logic [32:0] res_q[$];
    int          lat_q[$];
    int          cyc = 0;
    int          t_setx = 0;
    bit          prev_valid = 1'b0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_valid   = 1'b0;
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                check("hold_valid", bus.res_valid, 1);
                check("hold_data", bus.res_data, prev_data);
                check("hold_last", bus.res_last, prev_last);
                check("no_cmd_while_pending", bus.dp_en, 0);
            end
            if (bus.dp_en && bus.dp_cmd == 7'd8) begin
                setx_q.push_back(bus.dp_inp1);
                t_setx = cyc;
            end
            if (bus.dp_en && bus.dp_cmd == 7'd7) check("read_after_done", m_done, 1);
            if (bus.res_valid && !prev_valid) lat_q.push_back(cyc - t_setx);
            if (bus.res_valid && bus.res_ready) res_q.push_back({bus.res_last, bus.res_data});
            prev_valid   = bus.res_valid;
            prev_pending = bus.res_valid && !bus.res_ready;
            prev_data    = bus.res_data;
            prev_last    = bus.res_last;
        end
    end

    task automatic start_job(input logic [31:0] sx, input logic [15:0] cnt, input logic [7:0] rl);
        int g = 0;
        @(posedge clk);
        #1;
        while (!bus.job_ready && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("job_ready_wait", bus.job_ready, 1);
        bus.job_valid    = 1'b1;
        bus.job_start_x  = sx;
        bus.job_count    = cnt;
        bus.job_ring_len = rl;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (!bus.job_ready && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check("job_done_wait", bus.job_ready, 1);
    endtask

    task automatic clear_mon();
        setx_q.delete();
        res_q.delete();
        lat_q.delete();
    endtask

    // Full job against the reference: position list, results, last flag, latency
    task automatic run_job(input logic [31:0] sx, input int cnt, input logic [7:0] rl, input int d,
                           output logic [31:0] first_x, output logic [31:0] last_x);
        logic [31:0] exp_x[$];
        logic [31:0] x;
        int          eff;
        depth = d;
        clear_mon();
        eff = (rl == 0) ? 1 : int'(rl);
        x = (sx < 32'(eff)) ? sx : 32'd0;
        for (int i = 0; i < cnt; i++) begin
            exp_x.push_back(x);
            x = (x + 1 == 32'(eff)) ? 32'd0 : x + 1;
        end
        start_job(sx, 16'(cnt), rl);
        wait_idle();
        check("setx_count", setx_q.size(), cnt);
        check("res_count", res_q.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < setx_q.size()) check("setx_pos", setx_q[i], exp_x[i]);
            if (i < res_q.size()) begin
                check("res_data", res_q[i][31:0], ref_f(exp_x[i]));
                check("res_last", res_q[i][32], (i == cnt - 1));
            end
        end
        if (ready_mode == 0)
            for (int i = 0; i < lat_q.size(); i++) check("res_latency", lat_q[i], 2 * d + 7);
        first_x = (setx_q.size() > 0) ? setx_q[0] : 32'hFFFF_FFFF;
        last_x  = (setx_q.size() > 0) ? setx_q[setx_q.size()-1] : 32'hFFFF_FFFF;
    endtask

    typedef struct {
        logic [31:0] sx;
        int          cnt;
        logic [7:0]  rl;
        int          d;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] fx, lx, held;
        int          g, polls;

        vecs[0] = '{32'd0,  3, 8'd9, 2, 32'd0, 32'd2};
        vecs[1] = '{32'd8,  3, 8'd9, 2, 32'd8, 32'd1};
        vecs[2] = '{32'd20, 4, 8'd9, 1, 32'd0, 32'd3};
        vecs[3] = '{32'd5,  3, 8'd0, 3, 32'd0, 32'd0};
        vecs[4] = '{32'd3,  5, 8'd4, 2, 32'd3, 32'd3};

        bus.job_valid    = 1'b0;
        bus.job_start_x  = '0;
        bus.job_count    = '0;
        bus.job_ring_len = '0;
        bus.res_ready    = 1'b1;

        // Reset state
        #1;
        check("rst_job_ready", bus.job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_dp_en", bus.dp_en, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_err", err_timeout, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed table, immediate ready
        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].sx, vecs[i].cnt, vecs[i].rl, vecs[i].d, fx, lx);
            check("tbl_first_x", fx, vecs[i].exp_first);
            check("tbl_last_x", lx, vecs[i].exp_last);
        end

        // Empty job: one busy cycle, no commands, no result
        clear_mon();
        start_job(32'd1, 16'd0, 8'd9);
        @(negedge clk);
        check("cnt0_ready_low", bus.job_ready, 0);
        check("cnt0_no_en", bus.dp_en, 0);
        check("cnt0_no_valid", bus.res_valid, 0);
        @(negedge clk);
        check("cnt0_ready_back", bus.job_ready, 1);
        check("cnt0_no_setx", setx_q.size(), 0);
        check("cnt0_no_res", res_q.size(), 0);

        // Backpressure: result held 20 cycles, nothing issued meanwhile
        clear_mon();
        depth = 1;
        ready_mode = 2;
        start_job(32'd2, 16'd2, 8'd9);
        g = 0;
        @(negedge clk);
        while (!bus.res_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("bp_valid_seen", bus.res_valid, 1);
        held = bus.res_data;
        check("bp_data", held, ref_f(32'd2));
        repeat (20) begin
            @(negedge clk);
            check("bp_stable_data", bus.res_data, held);
            check("bp_no_en", bus.dp_en, 0);
        end
        check("bp_one_setx", setx_q.size(), 1);
        ready_mode = 0;
        wait_idle();
        check("bp_res_count", res_q.size(), 2);
        if (res_q.size() == 2) begin
            check("bp_res1", res_q[1][31:0], ref_f(32'd3));
            check("bp_last1", res_q[1][32], 1);
        end

        // Random jobs with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 8; i++)
            run_job(32'($urandom_range(0, 20)), $urandom_range(1, 6), 8'($urandom_range(0, 12)),
                    $urandom_range(1, 3), fx, lx);
        ready_mode = 0;

`ifdef CONV1D_SEQ_TIMEOUT_EN
        // Poll timeout: conv1d never finishes
        clear_mon();
        stuck = 1'b1;
        depth = 1;
        start_job(32'd0, 16'd2, 8'd9);
        polls = 0;
        g = 0;
        @(negedge clk);
        while (!bus.job_ready && g < 500) begin
            if (bus.dp_en && bus.dp_cmd == 7'd9) polls++;
            @(negedge clk);
            g++;
        end
        check("to_idle", bus.job_ready, 1);
        check("to_polls", polls, 16);
        check("to_err", err_timeout, 1);
        check("to_no_res", res_q.size(), 0);
        stuck = 1'b0;
        run_job(32'd4, 2, 8'd9, 1, fx, lx);
        check("to_err_cleared", err_timeout, 0);
`else
        check("err_tied_low", err_timeout, 0);
`endif

        // Asynchronous reset in the middle of POLL
        clear_mon();
        depth = 3;
        start_job(32'd1, 16'd3, 8'd9);
        g = 0;
        @(negedge clk);
        while (!(bus.dp_en && bus.dp_cmd == 7'd9) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_poll_seen", bus.dp_cmd, 7'd9);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_job_ready", bus.job_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_dp_en", bus.dp_en, 0);
        check("arst_dp_cmd", bus.dp_cmd, 0);
        check("arst_dp_inp1", bus.dp_inp1, 0);
        check("arst_dp_inp0", bus.dp_inp0, 0);
        check("arst_res_valid", bus.res_valid, 0);
        check("arst_res_last", bus.res_last, 0);
        check("arst_res_data", bus.res_data, 0);
        check("arst_err", err_timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(32'd7, 3, 8'd9, 2, fx, lx);
        check("post_rst_first", fx, 32'd7);
        check("post_rst_last", lx, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
